// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use stall and branch-redirect flush control
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_hazard_clk,
  input  logic             i_hazard_reset,
  input  logic [31:0]      i_hazard_id_inst,
  input  logic [31:0]      i_hazard_ex_inst,
  input  logic             i_hazard_ex_rd_wren,
  input  logic [31:0]      i_hazard_mem_inst,
  input  logic             i_hazard_mem_rd_wren,
  input  logic [31:0]      i_hazard_wb_inst,
  input  logic             i_hazard_wb_rd_wren,
  input  logic             i_hazard_br_taken,
  output logic [1:0]       o_hazard_fwd_operand_a,
  output logic [1:0]       o_hazard_fwd_operand_b,
  output logic             o_hazard_stall,
  output logic             o_hazard_flush_if_id,
  output logic             o_hazard_flush_id_ex,
  output logic             o_hazard_flush_ex_mem,
  output logic [CNT_W-1:0] o_hazard_stall_cnt,
  output logic [CNT_W-1:0] o_hazard_flush_cnt
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state, next;
  logic run, br, lu, lu_ok;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic unused_bits;
  assign unused_bits = ^{i_hazard_id_inst, i_hazard_ex_inst, i_hazard_mem_inst, i_hazard_wb_inst};
  assign run    = i_hazard_reset;
  assign br     = i_hazard_br_taken;
  assign id_rs1 = i_hazard_id_inst[19:15];
  assign id_rs2 = i_hazard_id_inst[24:20];
  assign ex_rd  = i_hazard_ex_inst[11:7];
  assign ex_rs1 = i_hazard_ex_inst[19:15];
  assign ex_rs2 = i_hazard_ex_inst[24:20];
  assign mem_rd = i_hazard_mem_inst[11:7];
  assign wb_rd  = i_hazard_wb_inst[11:7];
  // x0 is excluded by requiring a nonzero producer rd
  always_comb begin
    o_hazard_fwd_operand_a = !run ? 2'b00 :
      (i_hazard_mem_rd_wren && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b01 :
      (i_hazard_wb_rd_wren && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
    o_hazard_fwd_operand_b = !run ? 2'b00 :
      (i_hazard_mem_rd_wren && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b01 :
      (i_hazard_wb_rd_wren && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
  end
  assign lu = i_hazard_ex_inst[6:0] == 7'b0000011 && i_hazard_ex_rd_wren &&
              ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  always_ff @(posedge i_hazard_clk)
    state <= !run ? RUN : next;
  always_comb
    next = br ? FLUSH : (state == RUN && lu) ? STALL : RUN;
  // a load-use event is only honoured from RUN, bounding every stall to one cycle
  always_comb begin
    lu_ok                 = lu && state == RUN;
    o_hazard_stall        = run && !br && lu_ok;
    o_hazard_flush_if_id  = run && br;
    o_hazard_flush_ex_mem = run && br;
    o_hazard_flush_id_ex  = run && (br || lu_ok);
  end
  always_ff @(posedge i_hazard_clk)
    if (!run) begin
      o_hazard_stall_cnt <= '0;
      o_hazard_flush_cnt <= '0;
    end else begin
      o_hazard_stall_cnt <= o_hazard_stall_cnt + CNT_W'(o_hazard_stall && !(&o_hazard_stall_cnt));
      o_hazard_flush_cnt <= o_hazard_flush_cnt + CNT_W'(br && !(&o_hazard_flush_cnt));
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stall/flush sequencing and saturating counters
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] id_inst, ex_inst, mem_inst, wb_inst;
  logic ex_w, mem_w, wb_w, br;
  logic [1:0] fwd_a, fwd_b;
  logic stall, f_if_id, f_id_ex, f_ex_mem;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int n_chk = 0, n_fail = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .i_hazard_clk(clk), .i_hazard_reset(rst_n),
    .i_hazard_id_inst(id_inst), .i_hazard_ex_inst(ex_inst), .i_hazard_ex_rd_wren(ex_w),
    .i_hazard_mem_inst(mem_inst), .i_hazard_mem_rd_wren(mem_w),
    .i_hazard_wb_inst(wb_inst), .i_hazard_wb_rd_wren(wb_w), .i_hazard_br_taken(br),
    .o_hazard_fwd_operand_a(fwd_a), .o_hazard_fwd_operand_b(fwd_b),
    .o_hazard_stall(stall), .o_hazard_flush_if_id(f_if_id),
    .o_hazard_flush_id_ex(f_id_ex), .o_hazard_flush_ex_mem(f_ex_mem),
    .o_hazard_stall_cnt(stall_cnt), .o_hazard_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] add(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic exw,
                       input logic [31:0] mem, input logic mw,
                       input logic [31:0] wb, input logic ww, input logic b);
    id_inst = id; ex_inst = ex; ex_w = exw; mem_inst = mem; mem_w = mw;
    wb_inst = wb; wb_w = ww; br = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flush(input string tag, input logic s, input logic a, input logic b, input logic c);
    chk({tag, "_stall"}, {7'd0, stall}, {7'd0, s});
    chk({tag, "_if_id"}, {7'd0, f_if_id}, {7'd0, a});
    chk({tag, "_id_ex"}, {7'd0, f_id_ex}, {7'd0, b});
    chk({tag, "_ex_mem"}, {7'd0, f_ex_mem}, {7'd0, c});
  endtask

  initial begin
    #2;
    // reset held: everything idle even with hazards and forwarding conditions present
    drive(add(8, 7, 1), lw(7, 5), 1, add(5, 0, 0), 1, add(5, 0, 0), 1, 1);
    chk_flush("rst", 0, 0, 0, 0);
    chk("rst_fwd_a", {6'd0, fwd_a}, 8'd0);
    tick(); tick();
    chk("rst_scnt", {4'd0, stall_cnt}, 8'd0);
    chk("rst_fcnt", {4'd0, flush_cnt}, 8'd0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_flush("idle", 0, 0, 0, 0);
    // forwarding
    drive(0, add(9, 5, 2), 1, add(5, 0, 0), 1, add(5, 0, 0), 1, 0);
    chk("fwd_mem_a", {6'd0, fwd_a}, 8'd1);
    chk("fwd_mem_b0", {6'd0, fwd_b}, 8'd0);
    drive(0, add(9, 3, 5), 1, add(5, 0, 0), 0, add(5, 0, 0), 1, 0);
    chk("fwd_wb_a0", {6'd0, fwd_a}, 8'd0);
    chk("fwd_wb_b", {6'd0, fwd_b}, 8'd2);
    drive(0, add(9, 3, 5), 1, add(5, 0, 0), 1, add(5, 0, 0), 1, 0);
    chk("fwd_prio_b", {6'd0, fwd_b}, 8'd1);
    drive(0, add(9, 0, 0), 1, add(0, 0, 0), 1, add(0, 0, 0), 1, 0);
    chk("fwd_x0_a", {6'd0, fwd_a}, 8'd0);
    chk("fwd_x0_b", {6'd0, fwd_b}, 8'd0);
    // load-use on rs1
    drive(add(8, 7, 1), lw(7, 2), 1, 0, 0, 0, 0, 0);
    chk_flush("lu", 1, 0, 1, 0);
    tick();
    chk_flush("lu_n1", 0, 0, 0, 0);
    chk("lu_scnt", {4'd0, stall_cnt}, 8'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // load-use on rs2 and non-hazard variants
    drive(add(8, 1, 7), lw(7, 2), 1, 0, 0, 0, 0, 0);
    chk("lu_rs2", {7'd0, stall}, 8'd1);
    drive(add(8, 0, 1), lw(0, 2), 1, 0, 0, 0, 0, 0);
    chk("lu_x0", {7'd0, stall}, 8'd0);
    drive(add(8, 7, 1), lw(7, 2), 0, 0, 0, 0, 0, 0);
    chk("lu_nowr", {7'd0, stall}, 8'd0);
    drive(add(8, 7, 1), add(7, 2, 3), 1, 0, 0, 0, 0, 0);
    chk("lu_noload", {7'd0, stall}, 8'd0);
    // branch beats load-use
    drive(add(8, 7, 1), lw(7, 2), 1, 0, 0, 0, 0, 1);
    chk_flush("br_lu", 0, 1, 1, 1);
    tick();
    chk("br_fcnt1", {4'd0, flush_cnt}, 8'd1);
    chk("br_scnt1", {4'd0, stall_cnt}, 8'd1);
    drive(add(8, 7, 1), lw(7, 2), 1, 0, 0, 0, 0, 0);
    chk_flush("flush_mask", 0, 0, 0, 0);
    tick();
    chk("run_lu", {7'd0, stall}, 8'd1);
    tick();
    chk("stall_mask", {7'd0, stall}, 8'd0);
    chk("scnt2", {4'd0, stall_cnt}, 8'd2);
    drive(add(8, 7, 1), lw(7, 2), 1, 0, 0, 0, 0, 1);
    chk_flush("stall_br", 0, 1, 1, 1);
    tick();
    chk("fcnt2", {4'd0, flush_cnt}, 8'd2);
    // flush counter saturation
    for (int i = 0; i < 16; i++) tick();
    chk("fcnt_sat", {4'd0, flush_cnt}, 8'd15);
    tick();
    chk("fcnt_hold", {4'd0, flush_cnt}, 8'd15);
    chk("scnt_nobr", {4'd0, stall_cnt}, 8'd2);
    // stall counter saturation: held load-use stalls every other cycle
    drive(add(8, 7, 1), lw(7, 2), 1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 40; i++) tick();
    chk("scnt_sat", {4'd0, stall_cnt}, 8'd15);
    chk("fcnt_keep", {4'd0, flush_cnt}, 8'd15);
    chk("run_again", {7'd0, stall}, 8'd1);
    tick();
    chk("in_stall", {7'd0, stall}, 8'd0);
    // reset during STALL
    rst_n = 1'b0;
    drive(add(8, 7, 1), lw(7, 2), 1, add(2, 0, 0), 1, 0, 0, 1);
    chk_flush("rst_stall", 0, 0, 0, 0);
    chk("rst_fwd", {6'd0, fwd_a}, 8'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rel_scnt", {4'd0, stall_cnt}, 8'd0);
    chk("rel_fcnt", {4'd0, flush_cnt}, 8'd0);
    chk_flush("rel", 0, 0, 0, 0);
    drive(add(8, 7, 1), lw(7, 2), 1, 0, 0, 0, 0, 0);
    chk("rel_run", {7'd0, stall}, 8'd1);
    tick();
    chk("rel_scnt1", {4'd0, stall_cnt}, 8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of each performance counter.
REQ-002 i_hazard_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_hazard_reset  in  1  reset, synchronous, active-low (0 = reset).
REQ-004 i_hazard_id_inst  in  32  instruction in decode stage.
REQ-005 i_hazard_ex_inst  in  32  instruction in execute stage.
REQ-006 i_hazard_ex_rd_wren  in  1  execute-stage register write enable.
REQ-007 i_hazard_mem_inst  in  32  instruction in MEM stage.
REQ-008 i_hazard_mem_rd_wren  in  1  MEM-stage register write enable.
REQ-009 i_hazard_wb_inst  in  32  instruction in writeback stage.
REQ-010 i_hazard_wb_rd_wren  in  1  writeback-stage register write enable.
REQ-011 i_hazard_br_taken  in  1  redirect resolved in MEM; younger instructions must be killed.
REQ-012 o_hazard_fwd_operand_a  out  2  execute operand-A forward select: 00 register file, 01 MEM ALU data, 10 WB data.
REQ-013 o_hazard_fwd_operand_b  out  2  execute operand-B forward select, same encoding.
REQ-014 o_hazard_stall  out  1  hold PC and IF/ID register.
REQ-015 o_hazard_flush_if_id  out  1  load NOP into IF/ID.
REQ-016 o_hazard_flush_id_ex  out  1  load NOP into ID/EX.
REQ-017 o_hazard_flush_ex_mem  out  1  load NOP into EX/MEM; drives the execute-stage flush input.
REQ-018 o_hazard_stall_cnt  out  CNT_W  saturating count of stall cycles.
REQ-019 o_hazard_flush_cnt  out  CNT_W  saturating count of redirect flushes.

Function
REQ-020 Fields: rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20]; register x0 never matches in any comparison.
REQ-021 Forward A = 01 when the MEM write enable is set and MEM rd equals EX rs1; else 10 when the WB write enable is set and WB rd equals EX rs1; else 00. MEM has priority over WB.
REQ-022 Forward B follows the REQ-021 rule, using EX rs2.
REQ-023 Forward selects are combinational, zero latency, and independent of FSM state.
REQ-024 Load-use hazard (LU) is true when all hold: EX opcode inst[6:0] = 7'b0000011; the EX write enable is set; EX rd is nonzero; EX rd equals ID rs1 or ID rs2. The rs2 compare applies to every format (conservative).
REQ-025 The FSM has three states: RUN, STALL, FLUSH. The state register is reset to RUN.
REQ-026 In RUN with br_taken = 1: the next state is FLUSH.
REQ-027 In RUN with br_taken = 0 and LU = 1: the next state is STALL.
REQ-028 In RUN with neither condition: the state stays RUN.
REQ-029 In STALL or FLUSH: the next state is FLUSH if br_taken = 1, else RUN.
REQ-030 LU is masked (treated as 0) in the STALL and FLUSH states, so one load-use event never stalls for more than one cycle.
REQ-031 Stall cycle: o_hazard_stall = 1 and o_hazard_flush_id_ex = 1 in the same cycle LU is accepted (combinational); all other flush outputs are 0.
REQ-032 Redirect cycle: while br_taken = 1, all three flush outputs are 1 and o_hazard_stall = 0, in any state. Branch redirect has priority over a simultaneous LU.
REQ-033 o_hazard_stall_cnt increments by 1 on each edge where o_hazard_stall = 1, saturating at all-ones.
REQ-034 o_hazard_flush_cnt increments by 1 on each edge where br_taken = 1, saturating at all-ones.
REQ-035 Forward, stall and flush outputs are combinational; counters are registered.

Reset
REQ-036 When i_hazard_reset = 0 at a rising edge: state becomes RUN and both counters become 0.
REQ-037 While i_hazard_reset = 0: o_hazard_stall and all flush outputs are 0, and forward selects are 00.
REQ-038 A reset asserted during STALL or FLUSH takes effect at that edge; the cycle after reset release is in RUN with no residual stall or flush.

Verification
REQ-039 EX = add x5 (wren 1), MEM = add x5 (wren 1), ID/EX rs1 = x5 -> fwd_a = 01.
REQ-040 MEM with wren 0, WB rd = x5 (wren 1), EX rs2 = x5 -> fwd_b = 10.
REQ-041 EX rs1 = x0 while MEM rd = x0 with wren 1 -> fwd_a = 00.
REQ-042 EX = lw x7 (wren 1), ID = add x8,x7,x1 -> cycle N: stall = 1, flush_id_ex = 1; N+1: stall = 0; stall_cnt = 1.
REQ-043 LU and br_taken in the same cycle -> stall = 0, all three flushes = 1, flush_cnt +1, next state FLUSH; with CNT_W = 4, 16 flushes -> flush_cnt holds at 15.
REQ-044 Reset pulled low during STALL -> counters = 0, outputs idle; first cycle after release with no LU -> stall = 0.
